kbd_matrix: RTL and testbench

KBD_MATRIX -- requirements
Module: kbd_matrix

---
 rtl/kbd_matrix.sv | 189 ++++++++++++++++++
 tb/tb_kbd_matrix.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix.sv
// kbd_matrix: PS/2 set-2 key strobes -> 8x8 key matrix with row-strobed
// column readback and an optional key event FIFO.
// Define KBD_EVENT_FIFO_EN to build the event FIFO; without it the
// ev_* outputs are tied off and ev_ack is ignored.
module kbd_matrix #(
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        clr,
    input  logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        any_key,
    output logic        ev_valid,
    output logic [7:0]  ev_data,
    input  logic        ev_ack,
    output logic        ev_overflow
);

    logic        strobe_q;
    logic [63:0] mat_q, mat_d;
    logic        lshift_q, lshift_d, rshift_q, rshift_d;
    logic [7:0]  col_q, col_d;
    logic        any_q;
    logic        strobe, pressed, map_hit, is_lshift, is_rshift, push;
    logic [5:0]  map_rc;
    logic [63:0] mat_eff;
    logic [7:0]  ev_byte;

    assign strobe    = ps2_key[10] ^ strobe_q;
    assign pressed   = ps2_key[9];
    assign is_lshift = ({ps2_key[8], ps2_key[7:0]} == 9'h012);
    assign is_rshift = ({ps2_key[8], ps2_key[7:0]} == 9'h059);

    // Shift keys share r7c0; the table never maps another key there.
    assign mat_eff = mat_q | {7'd0, lshift_q | rshift_q, 56'd0};

    // Fixed scancode table: {E0, code} -> {row, col}.
    always_comb begin
        map_hit = 1'b1;
        map_rc  = 6'd0;
        case ({ps2_key[8], ps2_key[7:0]})
            9'h01C: map_rc = {3'd4, 3'd4};  // A
            9'h029: map_rc = {3'd1, 3'd6};  // space
            9'h05A: map_rc = {3'd1, 3'd0};  // enter
            9'h16B: map_rc = {3'd1, 3'd1};  // left
            9'h174: map_rc = {3'd1, 3'd4};  // right
            9'h076: map_rc = {3'd1, 3'd3};  // esc
            9'h175: map_rc = {3'd1, 3'd2};  // up
            9'h172: map_rc = {3'd1, 3'd5};  // down
            9'h066: map_rc = {3'd1, 3'd7};  // backspace
            9'h016: map_rc = {3'd0, 3'd0};  // 1
            9'h01E: map_rc = {3'd0, 3'd1};  // 2
            9'h026: map_rc = {3'd0, 3'd2};  // 3
            9'h025: map_rc = {3'd0, 3'd3};  // 4
            9'h00D: map_rc = {3'd0, 3'd7};  // tab
            9'h015: map_rc = {3'd2, 3'd0};  // Q
            9'h01D: map_rc = {3'd2, 3'd1};  // W
            9'h024: map_rc = {3'd2, 3'd2};  // E
            9'h02D: map_rc = {3'd2, 3'd3};  // R
            9'h02C: map_rc = {3'd2, 3'd4};  // T
            9'h035: map_rc = {3'd2, 3'd5};  // Y
            9'h03C: map_rc = {3'd2, 3'd6};  // U
            9'h043: map_rc = {3'd2, 3'd7};  // I
            9'h044: map_rc = {3'd3, 3'd0};  // O
            9'h04D: map_rc = {3'd3, 3'd1};  // P
            9'h01B: map_rc = {3'd4, 3'd5};  // S
            9'h023: map_rc = {3'd4, 3'd6};  // D
            9'h02B: map_rc = {3'd4, 3'd7};  // F
            default: map_hit = 1'b0;
        endcase
    end

    // Matrix next state and event generation; an event only when the
    // effective matrix bit actually flips. clr wins over any strobe.
    always_comb begin
        mat_d    = mat_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        push     = 1'b0;
        ev_byte  = 8'h00;
        if (strobe) begin
            if (map_hit) begin
                mat_d[map_rc] = pressed;
                push          = (mat_q[map_rc] != pressed);
                ev_byte       = {pressed, 1'b0, map_rc};
            end else if (is_lshift || is_rshift) begin
                if (is_lshift) lshift_d = pressed;
                else           rshift_d = pressed;
                push    = ((lshift_d | rshift_d) != (lshift_q | rshift_q));
                ev_byte = {lshift_d | rshift_d, 1'b0, 6'o70};
            end
        end
        if (clr) begin
            mat_d    = 64'd0;
            lshift_d = 1'b0;
            rshift_d = 1'b0;
            push     = 1'b0;
        end
    end

    // Column readback: OR of all selected rows.
    always_comb begin
        col_d = 8'h00;
        for (int r = 0; r < 8; r++) begin
            if (row_sel[r]) col_d = col_d | mat_eff[8*r +: 8];
        end
    end

    // Strobe copy, matrix and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            mat_q    <= 64'd0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            col_q    <= 8'h00;
            any_q    <= 1'b0;
        end else begin
            strobe_q <= ps2_key[10];
            mat_q    <= mat_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            if (clr) begin
                col_q <= 8'h00;
                any_q <= 1'b0;
            end else begin
                col_q <= col_d;
                any_q <= |mat_eff;
            end
        end
    end

    assign col_data = col_q;
    assign any_key  = any_q;

`ifdef KBD_EVENT_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               pop, full, wr_en;

    assign pop   = ev_ack && (cnt_q != '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign wr_en = push && (!full || pop);

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + FIFO_AW'(1);
            if (pop)   rd_q <= rd_q + FIFO_AW'(1);
            if (wr_en && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!wr_en && pop) cnt_q <= cnt_q - CNT_W'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // Event storage; when full with a pop, the write reuses the head slot.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= ev_byte;
    end

    assign ev_valid    = (cnt_q != '0);
    assign ev_data     = mem_q[rd_q];
    assign ev_overflow = ovf_q;
`else
    logic unused_ev;
    assign unused_ev   = ^{ev_ack, push, ev_byte};
    assign ev_valid    = 1'b0;
    assign ev_data     = 8'h00;
    assign ev_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_matrix.sv
// Self-checking bench for kbd_matrix. Expected events go into a scoreboard
// queue; a negedge monitor compares ev_data whenever an event is acked.
module tb_kbd_matrix;

`ifdef KBD_EVENT_FIFO_EN
    localparam logic FIFO_ON = 1'b1;
`else
    localparam logic FIFO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clr;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        any_key;
    logic        ev_valid;
    logic [7:0]  ev_data;
    logic        ev_ack;
    logic        ev_overflow;

    logic        tog;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  sb [$];

    kbd_matrix #(.FIFO_AW(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .clr         (clr),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .any_key     (any_key),
        .ev_valid    (ev_valid),
        .ev_data     (ev_data),
        .ev_ack      (ev_ack),
        .ev_overflow (ev_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [7:0] b);
        if (FIFO_ON) sb.push_back(b);
    endtask

    task automatic key(input logic p, input logic e, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, p, e, code};
        tick();
    endtask

    task automatic colchk(input string nm, input logic [7:0] sel, input logic [7:0] exp);
        row_sel = sel;
        tick();
        chk(nm, col_data, exp);
    endtask

    task automatic ack(input int n);
        for (int i = 0; i < n; i++) begin
            ev_ack = 1'b1;
            tick();
            ev_ack = 1'b0;
        end
    endtask

    // Scoreboard monitor: each acked head event must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && ev_valid && ev_ack) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL ev_unexpected: got 0x%02h expected none", ev_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (ev_data !== e) begin
                    n_bad++;
                    $display("FAIL ev_data: got 0x%02h expected 0x%02h", ev_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [7:0] ovf_code [9];
    logic [7:0] ovf_ev   [9];
    logic [7:0] fill_code [8];
    logic       fill_ext  [8];
    logic [7:0] fill_ev   [8];

    initial begin
        ovf_code  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        ovf_ev    = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98};
        fill_code = '{8'h4D, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h72, 8'h66, 8'h0D};
        fill_ext  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        fill_ev   = '{8'h99, 8'hA5, 8'hA6, 8'hA7, 8'h8A, 8'h8D, 8'h8F, 8'h87};

        reset_n = 1'b0; ps2_key = '0; clr = 1'b0; row_sel = 8'h00; ev_ack = 1'b0; tog = 1'b0;
        repeat (2) tick();
        chk("rst_col", col_data, 8'h00);
        chk("rst_any", {7'd0, any_key}, 8'h00);
        chk("rst_valid", {7'd0, ev_valid}, 8'h00);
        chk("rst_ovf", {7'd0, ev_overflow}, 8'h00);

        // Strobe high at reset release: one press of A.
        tog = 1'b1; ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        tick();
        chk("rst_hold_any", {7'd0, any_key}, 8'h00);
        reset_n = 1'b1;
        expect_ev(8'hA4);
        tick();
        colchk("a_col", 8'h10, 8'h10);
        chk("a_any", {7'd0, any_key}, 8'h01);
        chk("a_valid", {7'd0, ev_valid}, {7'd0, FIFO_ON});
        chk("ev_data_off", ev_data, FIFO_ON ? ev_data : 8'h00);
        ack(1);
        chk("a_drained", {7'd0, ev_valid}, 8'h00);

        expect_ev(8'h24);
        key(1'b0, 1'b0, 8'h1C);
        colchk("a_rel_col", 8'h10, 8'h00);
        chk("a_rel_any", {7'd0, any_key}, 8'h00);
        ack(1);

        // Shift keys share r7c0.
        expect_ev(8'hB8);
        key(1'b1, 1'b0, 8'h12);
        colchk("lsh_col", 8'h80, 8'h01);
        key(1'b1, 1'b0, 8'h59);
        key(1'b0, 1'b0, 8'h12);
        colchk("rsh_hold_col", 8'h80, 8'h01);
        expect_ev(8'h38);
        key(1'b0, 1'b0, 8'h59);
        colchk("sh_rel_col", 8'h80, 8'h00);
        ack(2);
        chk("sh_drained", {7'd0, ev_valid}, 8'h00);

        // Typematic repeat, unmapped codes, release of an unheld key.
        expect_ev(8'h8E);
        repeat (3) key(1'b1, 1'b0, 8'h29);
        key(1'b1, 1'b0, 8'h00);
        colchk("space_col", 8'h02, 8'h40);
        expect_ev(8'h88);
        key(1'b1, 1'b0, 8'h5A);
        colchk("enter_col", 8'h02, 8'h41);
        expect_ev(8'h89);
        key(1'b1, 1'b1, 8'h6B);
        colchk("left_col", 8'h02, 8'h43);
        key(1'b1, 1'b0, 8'h6B);
        colchk("kp4_col", 8'h02, 8'h43);
        key(1'b0, 1'b0, 8'h76);
        colchk("esc_rel_col", 8'h02, 8'h43);
        ack(3);
        chk("rep_drained", {7'd0, ev_valid}, 8'h00);
        colchk("multi_row_col", 8'h12, 8'h43);
        colchk("no_row_col", 8'h00, 8'h00);
        expect_ev(8'h0E); key(1'b0, 1'b0, 8'h29);
        expect_ev(8'h08); key(1'b0, 1'b0, 8'h5A);
        expect_ev(8'h09); key(1'b0, 1'b1, 8'h6B);
        expect_ev(8'h8C); key(1'b1, 1'b1, 8'h74);
        expect_ev(8'h0C); key(1'b0, 1'b1, 8'h74);
        colchk("all_rel_col", 8'hFF, 8'h00);
        chk("all_rel_any", {7'd0, any_key}, 8'h00);
        ack(5);

        // Nine presses into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_ev(ovf_ev[i]);
            key(1'b1, 1'b0, ovf_code[i]);
        end
        chk("ovf_set", {7'd0, ev_overflow}, {7'd0, FIFO_ON});
        colchk("ovf_row3_col", 8'h08, 8'h01);
        colchk("ovf_row2_col", 8'h04, 8'hFF);
        ack(8);
        chk("ovf_drained", {7'd0, ev_valid}, 8'h00);
        chk("ovf_sticky", {7'd0, ev_overflow}, {7'd0, FIFO_ON});

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", {7'd0, ev_overflow}, 8'h00);
        chk("clr_any", {7'd0, any_key}, 8'h00);
        colchk("clr_col", 8'h0C, 8'h00);

        // Fill to full, then push with a simultaneous pop.
        for (int i = 0; i < 8; i++) begin
            expect_ev(fill_ev[i]);
            key(1'b1, fill_ext[i], fill_code[i]);
        end
        chk("full_no_ovf", {7'd0, ev_overflow}, 8'h00);
        expect_ev(8'h80);
        ev_ack = 1'b1;
        key(1'b1, 1'b0, 8'h16);
        ev_ack = 1'b0;
        chk("pushpop_no_ovf", {7'd0, ev_overflow}, 8'h00);
        chk("pushpop_valid", {7'd0, ev_valid}, {7'd0, FIFO_ON});
        colchk("fill_row0_col", 8'h01, 8'h81);
        ack(8);
        chk("fill_drained", {7'd0, ev_valid}, 8'h00);
        chk("fill_no_ovf", {7'd0, ev_overflow}, 8'h00);

        // clr beats a strobe and an ack in the same cycle.
        expect_ev(8'h81); key(1'b1, 1'b0, 8'h1E);
        expect_ev(8'h82); key(1'b1, 1'b0, 8'h26);
        row_sel = 8'h01;
        clr = 1'b1; ev_ack = 1'b1;
        key(1'b1, 1'b0, 8'h25);
        sb.delete();
        clr = 1'b0; ev_ack = 1'b0;
        chk("clrp_any", {7'd0, any_key}, 8'h00);
        chk("clrp_valid", {7'd0, ev_valid}, 8'h00);
        chk("clrp_ovf", {7'd0, ev_overflow}, 8'h00);
        chk("clrp_col", col_data, 8'h00);
        colchk("clrp_lost_col", 8'h01, 8'h00);
        chk("clrp_no_late_ev", {7'd0, ev_valid}, 8'h00);

        // Reset mid-operation drops queued events.
        expect_ev(8'h81);
        key(1'b1, 1'b0, 8'h1E);
        tick();
        chk("pre_rst_any", {7'd0, any_key}, 8'h01);
        chk("pre_rst_valid", {7'd0, ev_valid}, {7'd0, FIFO_ON});
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_any", {7'd0, any_key}, 8'h00);
        chk("mid_rst_col", col_data, 8'h00);
        chk("mid_rst_valid", {7'd0, ev_valid}, 8'h00);
        tog = 1'b0; ps2_key = '0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_valid", {7'd0, ev_valid}, 8'h00);
        chk("post_rst_any", {7'd0, any_key}, 8'h00);
        chk("sb_drain", 8'(sb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
